mem_stage: RTL
==============

# mem_stage

Memory-access pipeline stage of the RISC-V core. It sits between the EX/MEM latch and the MEM/WB latch. Non-memory instructions pass through combinationally. Loads and stores are sequenced byte-by-byte over the shared 8-bit RAM port, which the memory arbiter grants. While an access is in flight, the stage holds the pipeline through a stall request.

## Interface
Parameters:
- ADDR_W, 32, address and data-path width; ram_a width
- MAX_BYTES, 4, longest access (LW/SW)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global ready; low freezes all state
- ex_rd  in  5  destination register
- ex_vd  in  32  ALU result for non-memory ops
- ex_w_enable  in  1  register write enable
- ex_mem_op  in  4  memory op code
- ex_mem_addr  in  32  effective address
- ex_store_data  in  32  store data (rs2)
- mem_req  out  1  request for RAM port to arbiter
- mem_grant  in  1  arbiter grant; held high while mem_req is high
- ram_a  out  32  byte address
- ram_wr  out  1  1 = write byte
- ram_dout  out  8  write byte
- ram_din  in  8  read byte; valid one cycle after its address
- mem_rd  out  5  to MEM/WB and forwarding
- mem_vd  out  32  to MEM/WB and forwarding
- mem_w_enable  out  1  to MEM/WB and forwarding
- stall_req  out  1  to stall controller; freezes IF..EX/MEM

## Operation
- Op codes: MemNone=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8. Codes 9–15 behave as MemNone.
- Access size N: 1 for B, 2 for H, 4 for W. Byte order is little-endian.
- States: IDLE, ACCESS, DONE. There is a 3-bit byte index idx and a 32-bit load buffer.
- IDLE with MemNone:
  - mem_rd, mem_vd, mem_w_enable are driven from the ex_* inputs combinationally.
  - stall_req=0, mem_req=0.
- IDLE with a memory op:
  - mem_req=1, stall_req=1.
  - mem_rd, mem_vd, mem_w_enable are all 0.
  - At a clock edge with mem_grant=1: go to ACCESS with idx=0. Otherwise stay in IDLE.
- ACCESS, store:
  - Each cycle: ram_a = ex_mem_addr+idx (mod 2^32), ram_wr=1, ram_dout = ex_store_data[8*idx+7:8*idx].
  - After the idx=N-1 cycle, go to DONE.
- ACCESS, load:
  - For idx<N: ram_a = addr+idx, ram_wr=0.
  - For idx≥1: capture ram_din into buffer byte idx-1.
  - The idx=N cycle only captures; ram_a=0.
  - Then go to DONE.
- mem_req and stall_req stay 1 throughout ACCESS. Outputs are zeroed.
- DONE (exactly 1 cycle):
  - stall_req=0, mem_req=0, mem_rd=ex_rd.
  - Load: mem_vd = extended buffer (sign-extended for LB/LH, zero-extended for LBU/LHU/LW), mem_w_enable = ex_w_enable.
  - Store: mem_vd=0, mem_w_enable=0.
  - Next state is unconditionally IDLE. EX/MEM advances on this edge, so the same op is never re-executed.
- ram_wr is 0 whenever the block is not in a store ACCESS cycle, and whenever rdy=0.
- Misaligned addresses need no special handling. The address wraps at 0xFFFFFFFF→0.

## Timing
- Reset (async): state=IDLE, idx=0, buffer=0, every output 0. This applies mid-access too: a partial store is abandoned and no further bytes are written.
- rdy=0: state, idx and buffer hold, and ram_wr is gated to 0. Behaviour resumes identically when rdy returns high.
- With grant in the first cycle:
  - Load: 1 (IDLE) + N+1 (ACCESS) cycles with stall_req=1, then DONE. LW = 6 stall cycles, LB = 3.
  - Store: 1 + N stall cycles. SW = 5, SB = 2.
- Each cycle of grant delay adds one IDLE cycle.
- Pass-through path is zero-latency combinational. mem_* outputs are combinational in all states.

## Structure
- Shared config.v defines: op codes, MemOpBus (3:0), existing RegBus/RegAddrBus/Enable/Disable/ZeroWord, and state encodings.
- One sub-module, mem_load_ext: combinational. Takes op code and 32-bit buffer; returns the extended 32-bit value.
- The remainder (FSM, idx counter, buffer, port muxing) lives in mem_stage.

## Test plan
- ex_mem_op=0, ex_rd=5, ex_vd=0x1234, ex_w_enable=1 → same cycle mem_rd=5, mem_vd=0x1234, mem_w_enable=1, stall_req=0, mem_req=0.
- LW addr 0x100, grant held, RAM[0x100..0x103]=EF BE AD DE:
  - ram_a sequence 0x100–0x103.
  - stall_req high 6 cycles.
  - DONE shows mem_vd=0xDEADBEEF.
- LB addr 0x201, RAM[0x201]=0x80 → mem_vd=0xFFFFFF80. Same case with LBU → 0x00000080. LH at 0xFFFFFFFF reads bytes at 0xFFFFFFFF and 0x0.
- SW addr 0x10, data 0x11223344:
  - Four ram_wr cycles writing 44,33,22,11 to 0x10–0x13.
  - mem_w_enable=0 in DONE.
  - stall_req high 5 cycles.
- LW with mem_grant low 3 cycles: stall_req high 9 cycles, no ram_a activity before grant. Then rdy=0 for 2 cycles mid-ACCESS: result is unchanged and completion is delayed by 2.
- rst pulsed during cycle 2 of SW ACCESS: all outputs 0 immediately, bytes 2–3 never written, IDLE afterwards.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared op codes, FSM states and op-decoding helpers for the memory stage.
package mem_stage_pkg;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LH   = 4'd2;
  localparam logic [3:0] OP_LW   = 4'd3;
  localparam logic [3:0] OP_LBU  = 4'd4;
  localparam logic [3:0] OP_LHU  = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LHU);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  // Bytes moved by the op; 0 for anything that is not a memory access.
  function automatic logic [2:0] op_size(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 3'd1;
      OP_LH, OP_LHU, OP_SH: return 3'd2;
      OP_LW, OP_SW:         return 3'd4;
      default:              return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Sign/zero extension of the assembled load buffer according to the load op.
module mem_load_ext
  import mem_stage_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] buffer,
  output logic [31:0] value
);

  // Pick the extension; LW and anything else pass the buffer unchanged.
  always_comb begin
    value = buffer;
    case (op)
      OP_LB:   value = {{24{buffer[7]}}, buffer[7:0]};
      OP_LH:   value = {{16{buffer[15]}}, buffer[15:0]};
      OP_LBU:  value = {24'b0, buffer[7:0]};
      OP_LHU:  value = {16'b0, buffer[15:0]};
      default: value = buffer;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: pass-through for ALU ops, byte-serial loads/stores
// over the shared 8-bit RAM port, stalling the front of the pipe meanwhile.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MAX_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [4:0]        ex_rd,
  input  logic [ADDR_W-1:0] ex_vd,
  input  logic              ex_w_enable,
  input  logic [3:0]        ex_mem_op,
  input  logic [ADDR_W-1:0] ex_mem_addr,
  input  logic [ADDR_W-1:0] ex_store_data,
  output logic              mem_req,
  input  logic              mem_grant,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic [4:0]        mem_rd,
  output logic [ADDR_W-1:0] mem_vd,
  output logic              mem_w_enable,
  output logic              stall_req
);

  state_e                 state, state_nx;
  logic [2:0]             idx, idx_nx;
  logic [8*MAX_BYTES-1:0] buffer, buffer_nx;
  logic                   is_load, is_store, is_mem;
  logic [2:0]             nbytes;
  logic [1:0]             cap_sel;
  logic [ADDR_W-1:0]      byte_addr;
  logic [ADDR_W-1:0]      ext_value;

  assign is_load   = op_is_load(ex_mem_op);
  assign is_store  = op_is_store(ex_mem_op);
  assign is_mem    = is_load | is_store;
  assign nbytes    = op_size(ex_mem_op);
  assign byte_addr = ex_mem_addr + ADDR_W'(idx);
  // RAM data lags its address by a cycle, so the byte arriving now belongs
  // to the previous index.
  assign cap_sel   = 2'(idx - 3'd1);

  mem_load_ext u_ext (
    .op     (ex_mem_op),
    .buffer (buffer),
    .value  (ext_value)
  );

  // State, byte index and load buffer; all frozen while rdy is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      idx    <= '0;
      buffer <= '0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      buffer <= buffer_nx;
    end
  end

  // Next-state: wait for grant, walk the bytes, one DONE cycle, back to IDLE.
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    buffer_nx = buffer;
    if (rdy) begin
      case (state)
        S_IDLE: begin
          if (is_mem && mem_grant) begin
            state_nx  = S_ACCESS;
            idx_nx    = '0;
            buffer_nx = '0;
          end
        end
        S_ACCESS: begin
          if (is_store) begin
            if (idx == nbytes - 3'd1) begin
              state_nx = S_DONE;
              idx_nx   = '0;
            end else begin
              idx_nx = idx + 3'd1;
            end
          end else begin
            if (idx != 3'd0) buffer_nx[{cap_sel, 3'b000} +: 8] = ram_din;
            // Loads need one extra cycle to catch the last byte.
            if (idx == nbytes) begin
              state_nx = S_DONE;
              idx_nx   = '0;
            end else begin
              idx_nx = idx + 3'd1;
            end
          end
        end
        S_DONE:  state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Output muxing; everything is forced low while reset is asserted.
  always_comb begin
    mem_req      = 1'b0;
    stall_req    = 1'b0;
    ram_a        = '0;
    ram_wr       = 1'b0;
    ram_dout     = '0;
    mem_rd       = '0;
    mem_vd       = '0;
    mem_w_enable = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          if (is_mem) begin
            mem_req   = 1'b1;
            stall_req = 1'b1;
          end else begin
            mem_rd       = ex_rd;
            mem_vd       = ex_vd;
            mem_w_enable = ex_w_enable;
          end
        end
        S_ACCESS: begin
          mem_req   = 1'b1;
          stall_req = 1'b1;
          if (is_store) begin
            ram_a    = byte_addr;
            ram_wr   = rdy;
            ram_dout = ex_store_data[{idx[1:0], 3'b000} +: 8];
          end else if (idx < nbytes) begin
            ram_a = byte_addr;
          end
        end
        S_DONE: begin
          mem_rd = ex_rd;
          if (is_load) begin
            mem_vd       = ext_value;
            mem_w_enable = ex_w_enable;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
